// File: rtl/master_fifo_pkg.sv
// Shared types and constant helpers for the master-side FIFO family
// (single-clock and async variants).
package master_fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH_WIDTH = 9;

   // Level width of the default 512-deep configuration, shared with the async variant.
   typedef logic [DEFAULT_DEPTH_WIDTH:0] fifo_level_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RESET = '{
      overflow:     1'b0,
      underflow:    1'b0,
      almost_full:  1'b0,
      almost_empty: 1'b1
   };

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   function automatic int unsigned fifo_depth(input int unsigned depth_width);
      return 32'd1 << depth_width;
   endfunction

endpackage

// File: rtl/master_fifo_sdp_ram.sv
// Simple dual-port RAM with a registered read port; the read register is the
// only resettable state, the array itself is never cleared.
module master_fifo_sdp_ram
   import master_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 72,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned WORDS = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [0:WORDS-1];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/master_sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, water level,
// programmable almost flags, synchronous flush and sticky overflow/underflow.
module master_sync_fifo_fwft
   import master_fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = 72,
   parameter int DEPTH_WIDTH      = 9,
   parameter int FWFT             = 0,
   parameter int ALMOST_FULL_NUM  = 60,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   wr_en,
   output logic                   wr_full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_empty,
   output logic                   almost_empty,
   output logic [DEPTH_WIDTH:0]   water_level,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned DEPTH = fifo_depth(DEPTH_WIDTH);
   localparam int          AW    = clog2(DEPTH);

   localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);
   localparam logic [AW:0] AF_LVL   = (AW + 1)'(ALMOST_FULL_NUM);
   localparam logic [AW:0] AE_LVL   = (AW + 1)'(ALMOST_EMPTY_NUM);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]  level_q, level_d;
   logic         pf_valid_q, pf_valid_d;
   fifo_flags_t  flags_q, flags_d;

   logic         mem_empty;
   logic         ptr_full;
   logic         lvl_full;
   logic         wr_acc;
   logic         rd_acc;
   logic         ram_rd;

   // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
   assign mem_empty = (wr_ptr_q == rd_ptr_q);
   assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign lvl_full  = (level_q == LVL_FULL);

   // In fall-through mode the prefetch word counts toward capacity, so the
   // memory pointers alone cannot tell full; the level counter can.
   assign wr_full  = (FWFT != 0) ? lvl_full : ptr_full;
   assign rd_empty = (FWFT != 0) ? !pf_valid_q : mem_empty;

   assign wr_acc = wr_en && !wr_full && !flush;
   assign rd_acc = rd_en && !rd_empty && !flush;

   // Fall-through refills the prefetch register whenever it is empty or being
   // popped, which gives back-to-back pops without a bubble.
   assign ram_rd = (FWFT != 0) ? (!mem_empty && (!pf_valid_q || rd_acc) && !flush)
                               : rd_acc;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      pf_valid_d = pf_valid_q;
      flags_d    = flags_q;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         pf_valid_d = 1'b0;
         flags_d    = FLAGS_RESET;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + LVL_ONE;
         end
         if (ram_rd) begin
            rd_ptr_d = rd_ptr_q + LVL_ONE;
         end

         if (wr_acc && !rd_acc) begin
            level_d = level_q + LVL_ONE;
         end else if (!wr_acc && rd_acc) begin
            level_d = level_q - LVL_ONE;
         end

         if (FWFT != 0) begin
            if (ram_rd) begin
               pf_valid_d = 1'b1;
            end else if (rd_acc) begin
               pf_valid_d = 1'b0;
            end
         end

         flags_d.overflow     = flags_q.overflow  | (wr_en & wr_full);
         flags_d.underflow    = flags_q.underflow | (rd_en & rd_empty);
         flags_d.almost_full  = (level_d >= AF_LVL);
         flags_d.almost_empty = (level_d <= AE_LVL);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         pf_valid_q <= 1'b0;
         flags_q    <= FLAGS_RESET;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         pf_valid_q <= pf_valid_d;
         flags_q    <= flags_d;
      end
   end

   master_fifo_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (rd_data)
   );

   assign water_level  = level_q;
   assign almost_full  = flags_q.almost_full;
   assign almost_empty = flags_q.almost_empty;
   assign overflow     = flags_q.overflow;
   assign underflow    = flags_q.underflow;

endmodule
